// File: rtl/testport_write_filter_if.sv
// Store-side and checker-side signal bundle for testport_write_filter.
// The master modport is the D-cache side; the slave modport is the filter.
interface testport_write_filter_if;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wen;
    logic        mem_stall;
    logic [29:0] addr;
    logic [31:0] data;
    logic        wen;

    modport master (
        output mem_addr, mem_wdata, mem_wen, mem_stall,
        input  addr, data, wen
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_wen, mem_stall,
        output addr, data, wen
    );
endinterface

// File: rtl/testport_write_filter.sv
// Filters completed D-cache stores to TEST_PORT, buffers them, and replays each one as an isolated wen pulse.
// Optional macro TPF_DROP_CNT_EN enables the saturating drop counter; otherwise drop_cnt is tied to zero.
module testport_write_filter #(
    parameter logic [29:0] TEST_PORT = 30'h3FF,
    parameter int          DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    testport_write_filter_if.slave    bus,
    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic                      overflow,
    output logic [15:0]               fwd_cnt,
    output logic [7:0]                drop_cnt
);
    localparam int          AW         = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PULSE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [61:0]   mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW:0]   level;
    logic          fifo_empty;
    logic          fifo_full;
    logic          accept;
    logic          pop;
    logic          push;
    logic          drop;
    logic [29:0]   addr_q;
    logic [31:0]   data_q;
    logic          wen_q;

    // A stalled cycle is the same store being held, so only the unstalled cycle counts.
    assign accept     = bus.mem_wen && !bus.mem_stall && (bus.mem_addr == TEST_PORT);
    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == FULL_LEVEL);
    assign pop        = ((state == ST_IDLE) || (state == ST_GAP)) && !fifo_empty;
    // A full FIFO still takes a store when the head leaves on the same edge.
    assign push       = accept && (!fifo_full || pop);
    assign drop       = accept && fifo_full && !pop;

    // NOTE: give every always_comb output a default first so no path infers a latch.
    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE:  state_nxt = pop ? ST_PULSE : ST_IDLE;
            ST_PULSE: state_nxt = ST_GAP;
            ST_GAP:   state_nxt = pop ? ST_PULSE : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            addr_q <= '0;
            data_q <= '0;
            wen_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (pop) begin
                addr_q <= mem[head][61:32];
                data_q <= mem[head][31:0];
                wen_q  <= 1'b1;
            end else begin
                addr_q <= '0;
                data_q <= '0;
                wen_q  <= 1'b0;
            end
        end
    end

    // NOTE: the storage array is not reset; clearing level and pointers makes old contents unreachable.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= {bus.mem_addr, bus.mem_wdata};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            level <= '0;
        end else begin
            if (push) begin
                tail <= tail + AW'(1);
            end
            if (pop) begin
                head <= head + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + (AW + 1)'(1);
                2'b01:   level <= level - (AW + 1)'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
            fwd_cnt  <= '0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end
            if (pop && (fwd_cnt != 16'hFFFF)) begin
                fwd_cnt <= fwd_cnt + 16'd1;
            end
        end
    end

`ifdef TPF_DROP_CNT_EN
    logic [7:0] drop_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_q <= '0;
        end else if (drop && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = 8'd0;
`endif

    assign fifo_level = level;
    assign bus.addr   = addr_q;
    assign bus.data   = data_q;
    assign bus.wen    = wen_q;
endmodule

// File: tb/tb_testport_write_filter.sv
// Directed bench for testport_write_filter: a per-cycle vector table plus burst, overflow and reset sequences.
module tb_testport_write_filter;
    localparam logic [29:0] TP = 30'h3FF;

    logic        clk;
    logic        rst;
    logic [2:0]  fifo_level;
    logic        overflow;
    logic [15:0] fwd_cnt;
    logic [7:0]  drop_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_fwd  = 0;

    testport_write_filter_if bus ();

    testport_write_filter #(.TEST_PORT(TP), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .fwd_cnt    (fwd_cnt),
        .drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected bench to finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        wen;
        logic        stall;
        logic [29:0] a;
        logic [31:0] d;
        logic        ewen;
        logic [29:0] ea;
        logic [31:0] ed;
        logic [2:0]  elvl;
        logic [15:0] efwd;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(input logic w, input logic s, input logic [29:0] a, input logic [31:0] d,
                                input logic ew, input logic [31:0] ed, input logic [2:0] el,
                                input logic [15:0] ef);
        vec_t v;
        v.wen   = w;
        v.stall = s;
        v.a     = a;
        v.d     = d;
        v.ewen  = ew;
        v.ea    = ew ? TP : 30'h0;
        v.ed    = ed;
        v.elvl  = el;
        v.efwd  = ef;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic w, input logic s, input logic [29:0] a, input logic [31:0] d);
        bus.mem_wen   = w;
        bus.mem_stall = s;
        bus.mem_addr  = a;
        bus.mem_wdata = d;
    endtask

    task automatic apply_reset();
        drive(1'b0, 1'b0, 30'h0, 32'h0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        exp_fwd = 0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_wen"},      64'(bus.wen), 64'd0);
        check({tag, "_addr"},     64'(bus.addr), 64'd0);
        check({tag, "_data"},     64'(bus.data), 64'd0);
        check({tag, "_level"},    64'(fifo_level), 64'd0);
        check({tag, "_overflow"}, 64'(overflow), 64'd0);
        check({tag, "_fwd_cnt"},  64'(fwd_cnt), 64'd0);
        check({tag, "_drop_cnt"}, 64'(drop_cnt), 64'd0);
    endtask

    // Stores n TEST_PORT words carrying data 0..n-1 on consecutive edges and checks the replay.
    task automatic run_burst(input string name, input int n, input int exp_pulses,
                             input logic exp_ovf, input logic [7:0] exp_drop);
        int got = 0;
        int peak = 0;
        bit idle_bad = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc < n) drive(1'b1, 1'b0, TP, 32'(cyc));
            else drive(1'b0, 1'b0, 30'h0, 32'h0);
            @(posedge clk);
            #1;
            if (int'(fifo_level) > peak) peak = int'(fifo_level);
            if (bus.wen) begin
                check($sformatf("%s_pulse%0d_data", name, got), 64'(bus.data), 64'(got));
                check($sformatf("%s_pulse%0d_addr", name, got), 64'(bus.addr), 64'(TP));
                check($sformatf("%s_pulse%0d_edge", name, got), 64'(cyc), 64'(1 + 2 * got));
                got++;
            end else if (bus.addr != 30'h0 || bus.data != 32'h0) begin
                idle_bad = 1'b1;
            end
            if (n == 9 && cyc == 7) begin
                check({name, "_full_push_pop_level"}, 64'(fifo_level), 64'd4);
                check({name, "_no_overflow_yet"}, 64'(overflow), 64'd0);
            end
        end
        exp_fwd += exp_pulses;
        check({name, "_pulse_count"}, 64'(got), 64'(exp_pulses));
        check({name, "_peak_level"}, 64'(peak), 64'd4);
        check({name, "_idle_bus_zero"}, 64'(idle_bad), 64'd0);
        check({name, "_overflow"}, 64'(overflow), 64'(exp_ovf));
        check({name, "_drop_cnt"}, 64'(drop_cnt), 64'(exp_drop));
        check({name, "_fwd_cnt"}, 64'(fwd_cnt), 64'(exp_fwd));
        check({name, "_final_level"}, 64'(fifo_level), 64'd0);
    endtask

    initial begin
        logic [7:0] ovf_drop;
`ifdef TPF_DROP_CNT_EN
        ovf_drop = 8'd1;
`else
        ovf_drop = 8'd0;
`endif
        // Single store, stalled store, filtered addresses; expected outputs are after each edge.
        vecs[0]  = mk(1, 0, TP,       32'h168, 0, 32'h0,   3'd1, 16'd0);
        vecs[1]  = mk(0, 0, 30'h0,    32'h0,   1, 32'h168, 3'd0, 16'd1);
        vecs[2]  = mk(0, 0, 30'h0,    32'h0,   0, 32'h0,   3'd0, 16'd1);
        vecs[3]  = mk(0, 0, 30'h0,    32'h0,   0, 32'h0,   3'd0, 16'd1);
        vecs[4]  = mk(1, 1, TP,       32'hA5,  0, 32'h0,   3'd0, 16'd1);
        vecs[5]  = mk(1, 1, TP,       32'hA5,  0, 32'h0,   3'd0, 16'd1);
        vecs[6]  = mk(1, 1, TP,       32'hA5,  0, 32'h0,   3'd0, 16'd1);
        vecs[7]  = mk(1, 0, TP,       32'hA5,  0, 32'h0,   3'd1, 16'd1);
        vecs[8]  = mk(0, 0, 30'h0,    32'h0,   1, 32'hA5,  3'd0, 16'd2);
        vecs[9]  = mk(0, 0, 30'h0,    32'h0,   0, 32'h0,   3'd0, 16'd2);
        vecs[10] = mk(0, 0, 30'h0,    32'h0,   0, 32'h0,   3'd0, 16'd2);
        vecs[11] = mk(1, 0, 30'h100,  32'h11,  0, 32'h0,   3'd0, 16'd2);
        vecs[12] = mk(1, 0, 30'h3FE,  32'h22,  0, 32'h0,   3'd0, 16'd2);
        vecs[13] = mk(1, 0, TP,       32'h33,  0, 32'h0,   3'd1, 16'd2);
        vecs[14] = mk(1, 0, 30'h100,  32'h44,  1, 32'h33,  3'd0, 16'd3);
        vecs[15] = mk(1, 0, 30'h3FE,  32'h55,  0, 32'h0,   3'd0, 16'd3);
        vecs[16] = mk(0, 0, TP,       32'h66,  0, 32'h0,   3'd0, 16'd3);
        vecs[17] = mk(1, 1, TP,       32'h77,  0, 32'h0,   3'd0, 16'd3);
        vecs[18] = mk(0, 0, 30'h0,    32'h0,   0, 32'h0,   3'd0, 16'd3);

        rst = 1'b1;
        drive(1'b0, 1'b0, 30'h0, 32'h0);
        #2;
        apply_reset();
        #1;
        check_reset_values("reset");

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].wen, vecs[i].stall, vecs[i].a, vecs[i].d);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_wen", i),      64'(bus.wen),    64'(vecs[i].ewen));
            check($sformatf("vec%0d_addr", i),     64'(bus.addr),   64'(vecs[i].ea));
            check($sformatf("vec%0d_data", i),     64'(bus.data),   64'(vecs[i].ed));
            check($sformatf("vec%0d_level", i),    64'(fifo_level), 64'(vecs[i].elvl));
            check($sformatf("vec%0d_fwd_cnt", i),  64'(fwd_cnt),    64'(vecs[i].efwd));
            check($sformatf("vec%0d_overflow", i), 64'(overflow),   64'd0);
        end

        apply_reset();
        run_burst("burst7", 7, 7, 1'b0, 8'd0);

        apply_reset();
        run_burst("burst9", 9, 8, 1'b1, ovf_drop);

        // Reset mid-burst: six stores leave level 3 with a pulse on the bus, then reset lands between edges.
        for (int cyc = 0; cyc < 6; cyc++) begin
            drive(1'b1, 1'b0, TP, 32'(cyc + 16));
            @(posedge clk);
            #1;
        end
        drive(1'b0, 1'b0, 30'h0, 32'h0);
        check("midrst_pre_level", 64'(fifo_level), 64'd3);
        check("midrst_pre_wen", 64'(bus.wen), 64'd1);
        check("midrst_pre_overflow", 64'(overflow), 64'd1);
        rst = 1'b0;
        #1;
        check_reset_values("midrst");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        begin
            int stray = 0;
            for (int cyc = 0; cyc < 10; cyc++) begin
                @(posedge clk);
                #1;
                if (bus.wen || fifo_level != 3'd0) stray++;
            end
            check("midrst_no_stray_pulse", 64'(stray), 64'd0);
            check("midrst_fwd_after", 64'(fwd_cnt), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
